cpu_regfile_mp: RTL and testbench
=================================

# cpu_regfile_mp

Parametrised multi-port CPU register file: the next generation of the core's integer register file. It has configurable depth, width and read-port count, and optional hard-wired-zero register 0. It adds same-cycle write-to-read bypass and a hardware scrub engine that zeroes every entry after reset or on request. It sits between the decode stage (read addresses) and the writeback stage (write port).

## Interface
Parameters:
- Count, 32: number of registers, 2..256, need not be a power of two.
- DataWidth, 32: register width in bits, ≥1.
- ReadPorts, 2: number of independent read ports, 1..4.
- ZeroReg, 1: 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is an ordinary register.
- Bypass, 1: 1 = forward a same-cycle write to matching reads; 0 = reads return the pre-write value.
- AddrWidth, localparam = $clog2(Count).

Ports:
- clk, in, 1: the single clock; all state updates on its rising edge.
- reset_n, in, 1: reset, asynchronous assert, active-low.
- write_data_i, in, DataWidth: write data.
- write_addr_i, in, AddrWidth: write index.
- write_enable_i, in, 1: write strobe.
- read_addr_i, in, ReadPorts*AddrWidth: read indices; port p occupies bits [p*AddrWidth +: AddrWidth].
- read_data_o, out, ReadPorts*DataWidth: registered read data; port p occupies bits [p*DataWidth +: DataWidth].
- clear_i, in, 1: request a scrub; sampled only in READY.
- busy_o, out, 1: high while scrubbing; writes are ignored while high.

## Operation
- FSM has two states: SCRUB and READY.
- Reset (reset_n=0):
  - FSM goes to SCRUB and the scrub counter goes to 0.
  - busy_o=1 and all read_data_o bits are 0.
  - Storage array is not reset; the scrub clears it.
- SCRUB:
  - Each cycle writes 0 to entry[counter], then counter+1.
  - After writing entry Count-1, the next state is READY.
  - write_enable_i is ignored; reads return 0 on every port.
- READY:
  - A write is committed when write_enable_i=1, write_addr_i<Count, and not (ZeroReg=1 and write_addr_i=0).
  - clear_i=1 moves the FSM to SCRUB on the next edge with counter=0.
  - If clear_i and a write occur in the same cycle, clear wins and the write is dropped.
- Reads, per port p, evaluated independently:
  - Address ≥Count, or (ZeroReg=1 and address=0): result is 0.
  - Otherwise, if Bypass=1 and a write is committed this cycle to the same address: result is write_data_i.
  - Otherwise: result is the stored value.
  - The result is registered into read_data_o.
- Several ports reading the same address all receive the same value.
- Out-of-range writes are silently dropped and no entry is aliased.

## Timing
- Read latency is 1 cycle: an address presented at edge N produces data valid after edge N.
- read_data_o holds its value while the address is stable.
- Write latency:
  - With Bypass=1, the written value is visible on the same edge the write commits.
  - With Bypass=0, it is visible one edge later.
- Scrub duration is exactly Count cycles. busy_o falls on the edge that writes entry Count-1.
- The first cycle with busy_o=0 accepts a write.
- clear_i sampled at edge N sets busy_o=1 after edge N. Any read sampled at edge N+1 or later returns 0 until the scrub completes.
- clear_i is ignored while busy_o=1; the counter does not restart.
- Reset asserted mid-scrub or mid-operation forces SCRUB with counter=0 immediately. A full Count-cycle scrub runs after release.
- No combinational path exists from any input to any output.

## Test plan
- Reset release, default parameters: busy_o=1 for exactly 32 cycles, then 0. All 32 registers then read 0 on both ports.
- Write 0xDEADBEEF to r5, then read r5 on port 0 and r5 on port 1: both return 0xDEADBEEF one cycle after the address. Write to r0, then read r0: returns 0.
- Bypass=1: at the same edge, write 0x12345678 to r7 and read r7 → read_data_o returns 0x12345678. With Bypass=0 the same stimulus returns the old value, and the next cycle returns 0x12345678.
- Fill r1..r31 with distinct values, then pulse clear_i together with a write to r3. The write is dropped, busy_o is high for 32 cycles, and every register reads 0 afterwards.
- Assert reset_n=0 at scrub cycle 10, then release: busy_o stays high for a full 32 cycles. A write attempted during the scrub leaves its target at 0.
- Count=24, ReadPorts=3: a write to address 27 is dropped, and reads of 27 return 0. Entries 0..23 behave normally, and the scrub lasts 24 cycles.

Source files
------------

// File: rtl/cpu_regfile_mp.sv
// Multi-port integer register file with same-cycle write-to-read bypass and a
// scrub engine that zeroes every entry after reset or when clear_i is pulsed.
//   state | meaning
//   SCRUB | zero entry[r_cnt] each cycle, reads return 0, writes ignored
//   READY | normal read/write operation, clear_i starts a new scrub
module cpu_regfile_mp #(
  parameter int Count     = 32,
  parameter int DataWidth = 32,
  parameter int ReadPorts = 2,
  parameter bit ZeroReg   = 1'b1,
  parameter bit Bypass    = 1'b1,
  localparam int AddrWidth = $clog2(Count)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [DataWidth-1:0]           write_data_i,
  input  logic [AddrWidth-1:0]           write_addr_i,
  input  logic                           write_enable_i,
  input  logic [ReadPorts*AddrWidth-1:0] read_addr_i,
  output logic [ReadPorts*DataWidth-1:0] read_data_o,
  input  logic                           clear_i,
  output logic                           busy_o
);

  if (Count < 2 || Count > 256) begin : g_bad_count
    $error("cpu_regfile_mp: Count must be in 2..256");
  end
  if (ReadPorts < 1 || ReadPorts > 4) begin : g_bad_ports
    $error("cpu_regfile_mp: ReadPorts must be in 1..4");
  end

  typedef enum logic {
    SCRUB = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [AddrWidth:0]   CountExt = (AddrWidth + 1)'(Count);
  localparam logic [AddrWidth-1:0] LastIdx  = AddrWidth'(Count - 1);

  state_t               r_state;
  logic [AddrWidth-1:0] r_cnt;
  logic                 r_busy;
  logic [DataWidth-1:0] r_mem   [Count];
  logic [DataWidth-1:0] r_rdata [ReadPorts];

  logic                 w_waddr_ok;
  logic                 w_commit;
  logic                 w_mem_we;
  logic [AddrWidth-1:0] w_mem_addr;
  logic [DataWidth-1:0] w_mem_data;
  logic [DataWidth-1:0] w_rnext [ReadPorts];

  // clear_i takes priority: a write in the same cycle as a clear is dropped
  assign w_waddr_ok = ({1'b0, write_addr_i} < CountExt) &&
                      !(ZeroReg && (write_addr_i == '0));
  assign w_commit   = (r_state == READY) && write_enable_i && w_waddr_ok && !clear_i;

  // the scrub engine shares the single array write port with the writeback path
  assign w_mem_we   = (r_state == SCRUB) || w_commit;
  assign w_mem_addr = (r_state == SCRUB) ? r_cnt : write_addr_i;
  assign w_mem_data = (r_state == SCRUB) ? '0 : write_data_i;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  for (genvar p = 0; p < ReadPorts; p++) begin : g_rd
    logic [AddrWidth-1:0] w_raddr;
    logic                 w_rok;
    logic                 w_fwd;

    assign w_raddr = read_addr_i[p*AddrWidth +: AddrWidth];
    assign w_rok   = (r_state == READY) && ({1'b0, w_raddr} < CountExt) &&
                     !(ZeroReg && (w_raddr == '0));
    assign w_fwd   = Bypass && w_commit && (w_raddr == write_addr_i);

    assign w_rnext[p] = !w_rok ? '0 :
                        w_fwd  ? write_data_i : r_mem[w_raddr];

    assign read_data_o[p*DataWidth +: DataWidth] = r_rdata[p];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SCRUB;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      for (int p = 0; p < ReadPorts; p++) begin
        r_rdata[p] <= '0;
      end
    end else begin
      for (int p = 0; p < ReadPorts; p++) begin
        r_rdata[p] <= w_rnext[p];
      end
      case (r_state)
        SCRUB: begin
          if (r_cnt == LastIdx) begin
            r_state <= READY;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        READY: begin
          if (clear_i) begin
            r_state <= SCRUB;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign busy_o = r_busy;

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// Bench for cpu_regfile_mp: three instances (default, no-bypass with plain r0,
// 24-entry 3-port) driven in lockstep and compared against one reference model.
module tb_cpu_regfile_mp;
  localparam int NI = 3;

  logic        clk            = 1'b0;
  logic        reset_n        = 1'b0;
  logic [31:0] write_data_i   = '0;
  logic [4:0]  write_addr_i   = '0;
  logic        write_enable_i = 1'b0;
  logic [14:0] read_addr_i    = '0;
  logic        clear_i        = 1'b0;
  logic [63:0] rd_a, rd_b;
  logic [95:0] rd_c;
  logic        busy_a, busy_b, busy_c;

  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_en   = 1'b0;

  always #5 clk = ~clk;

  cpu_regfile_mp u_a (
    .clk(clk), .reset_n(reset_n), .write_data_i(write_data_i), .write_addr_i(write_addr_i),
    .write_enable_i(write_enable_i), .read_addr_i(read_addr_i[9:0]), .read_data_o(rd_a),
    .clear_i(clear_i), .busy_o(busy_a));

  cpu_regfile_mp #(.Bypass(1'b0), .ZeroReg(1'b0)) u_b (
    .clk(clk), .reset_n(reset_n), .write_data_i(write_data_i), .write_addr_i(write_addr_i),
    .write_enable_i(write_enable_i), .read_addr_i(read_addr_i[9:0]), .read_data_o(rd_b),
    .clear_i(clear_i), .busy_o(busy_b));

  cpu_regfile_mp #(.Count(24), .ReadPorts(3)) u_c (
    .clk(clk), .reset_n(reset_n), .write_data_i(write_data_i), .write_addr_i(write_addr_i),
    .write_enable_i(write_enable_i), .read_addr_i(read_addr_i), .read_data_o(rd_c),
    .clear_i(clear_i), .busy_o(busy_c));

  logic [31:0] obs_rd   [NI][3];
  logic        obs_busy [NI];
  assign obs_rd[0][0] = rd_a[31:0];
  assign obs_rd[0][1] = rd_a[63:32];
  assign obs_rd[0][2] = '0;
  assign obs_rd[1][0] = rd_b[31:0];
  assign obs_rd[1][1] = rd_b[63:32];
  assign obs_rd[1][2] = '0;
  assign obs_rd[2][0] = rd_c[31:0];
  assign obs_rd[2][1] = rd_c[63:32];
  assign obs_rd[2][2] = rd_c[95:64];
  assign obs_busy[0]  = busy_a;
  assign obs_busy[1]  = busy_b;
  assign obs_busy[2]  = busy_c;

  function automatic int f_cnt(int i);   return (i == 2) ? 24 : 32; endfunction
  function automatic int f_ports(int i); return (i == 2) ? 3 : 2;   endfunction
  function automatic bit f_zr(int i);    return i != 1;             endfunction
  function automatic bit f_byp(int i);   return i != 1;             endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: register contents plus number of scrub cycles still owed
  logic [31:0] m_mem  [NI][32];
  int          m_left [NI];
  logic [31:0] m_rd   [NI][3];
  bit          m_commit;
  int          m_a;

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) begin
        m_left[i] = f_cnt(i);
        for (int p = 0; p < 3; p++) m_rd[i][p] = '0;
      end else if (m_left[i] > 0) begin
        m_mem[i][f_cnt(i) - m_left[i]] = '0;
        m_left[i] = m_left[i] - 1;
        for (int p = 0; p < 3; p++) m_rd[i][p] = '0;
      end else begin
        m_commit = write_enable_i && (int'(write_addr_i) < f_cnt(i)) &&
                   !(f_zr(i) && write_addr_i == 5'd0) && !clear_i;
        for (int p = 0; p < f_ports(i); p++) begin
          m_a = int'(read_addr_i[p*5 +: 5]);
          if (m_a >= f_cnt(i) || (f_zr(i) && m_a == 0)) m_rd[i][p] = '0;
          else if (f_byp(i) && m_commit && m_a == int'(write_addr_i)) m_rd[i][p] = write_data_i;
          else m_rd[i][p] = m_mem[i][m_a];
        end
        if (m_commit) m_mem[i][write_addr_i] = write_data_i;
        if (clear_i) m_left[i] = f_cnt(i);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("busy[%0d]", i), 32'(obs_busy[i]), 32'(m_left[i] > 0));
        for (int p = 0; p < f_ports(i); p++)
          check($sformatf("rd[%0d][%0d]", i, p), obs_rd[i][p], m_rd[i][p]);
      end
    end
  end

  task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                     input logic clr);
    write_enable_i = we;
    write_addr_i   = wa;
    write_data_i   = wd;
    read_addr_i    = {r2, r1, r0};
    clear_i        = clr;
    @(negedge clk);
  endtask

  // Counts edges until busy falls on the 32-entry and 24-entry instances
  task automatic measure(input string tag, input int exp_a, input int exp_c, input bit poke);
    int na = 0;
    int nc = 0;
    for (int n = 1; n <= 100 && (na == 0 || nc == 0); n++) begin
      @(posedge clk);
      #1;
      if (na == 0 && !busy_a) na = n;
      if (nc == 0 && !busy_c) nc = n;
      if (poke && n == 20) begin
        write_enable_i = 1'b1;
        write_addr_i   = 5'd2;
        write_data_i   = 32'hBAD0_0002;
      end
      if (poke && n == 21) write_enable_i = 1'b0;
    end
    check({tag, "_len_a"}, 32'(na), 32'(exp_a));
    check({tag, "_len_c"}, 32'(nc), 32'(exp_c));
    @(negedge clk);
  endtask

  function automatic logic [31:0] fillv(int a);
    return 32'h1000_0000 + 32'(a) * 32'h0001_0101;
  endfunction

  initial begin
    logic [4:0] wa, ra0, ra1, ra2;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy_a", 32'(busy_a), 32'd1);
    check("rst_rd_a", rd_a[31:0], 32'd0);
    check("rst_rd_c", rd_c[95:64], 32'd0);
    #2 reset_n = 1'b1;
    measure("rst", 32, 24, 1'b0);

    for (int a = 0; a < 32; a++) begin
      drv(1'b0, 5'd0, 32'd0, 5'(a), 5'(a), 5'(a), 1'b0);
      check("init_zero_p0", rd_a[31:0], 32'd0);
      check("init_zero_p1", rd_a[63:32], 32'd0);
    end

    drv(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd1, 5'd1, 1'b0);
    drv(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5, 1'b0);
    check("r5_p0", rd_a[31:0], 32'hDEAD_BEEF);
    check("r5_p1", rd_a[63:32], 32'hDEAD_BEEF);
    check("r5_c_p2", rd_c[95:64], 32'hDEAD_BEEF);

    drv(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 5'd7, 1'b0);
    check("byp_a", rd_a[31:0], 32'h1234_5678);
    check("nobyp_b_old", rd_b[31:0], 32'd0);
    check("byp_c", rd_c[95:64], 32'h1234_5678);
    drv(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7, 1'b0);
    check("nobyp_b_new", rd_b[31:0], 32'h1234_5678);

    drv(1'b1, 5'd0, 32'hCAFE_F00D, 5'd0, 5'd0, 5'd0, 1'b0);
    check("r0_a_same", rd_a[31:0], 32'd0);
    drv(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("r0_a", rd_a[31:0], 32'd0);
    check("r0_b_plain", rd_b[31:0], 32'hCAFE_F00D);
    check("r0_c", rd_c[31:0], 32'd0);

    drv(1'b1, 5'd27, 32'h0000_A5A5, 5'd27, 5'd27, 5'd27, 1'b0);
    check("a27_byp", rd_a[31:0], 32'h0000_A5A5);
    check("c27_p0", rd_c[31:0], 32'd0);
    drv(1'b0, 5'd0, 32'd0, 5'd3, 5'd11, 5'd27, 1'b0);
    check("c_alias3", rd_c[31:0], 32'd0);
    check("c_alias11", rd_c[63:32], 32'd0);
    check("c27_read", rd_c[95:64], 32'd0);

    for (int a = 1; a < 32; a++) drv(1'b1, 5'(a), fillv(a), 5'(a), 5'(a), 5'(a), 1'b0);
    drv(1'b0, 5'd0, 32'd0, 5'd3, 5'd31, 5'd23, 1'b0);
    check("fill_r3", rd_a[31:0], fillv(3));
    check("fill_r31", rd_a[63:32], fillv(31));

    write_enable_i = 1'b1;
    write_addr_i   = 5'd3;
    write_data_i   = 32'hFFFF_0003;
    read_addr_i    = {5'd3, 5'd3, 5'd3};
    clear_i        = 1'b1;
    @(posedge clk);
    #1;
    check("clr_busy", 32'(busy_a), 32'd1);
    check("clr_drop_r3", rd_a[31:0], fillv(3));
    clear_i        = 1'b0;
    write_enable_i = 1'b0;
    measure("clr", 32, 24, 1'b0);
    for (int a = 0; a < 32; a++) begin
      drv(1'b0, 5'd0, 32'd0, 5'(a), 5'(a), 5'(a), 1'b0);
      check("clr_zero_a", rd_a[31:0], 32'd0);
      check("clr_zero_b", rd_b[63:32], 32'd0);
    end

    clear_i = 1'b1;
    @(posedge clk);
    #1 clear_i = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    check("mid_rst_busy", 32'(busy_a), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b1;
    measure("mrst", 32, 24, 1'b1);
    drv(1'b0, 5'd0, 32'd0, 5'd2, 5'd2, 5'd2, 1'b0);
    check("scrub_wr_a", rd_a[31:0], 32'd0);
    check("scrub_wr_c", rd_c[95:64], 32'd0);

    for (int k = 0; k < 3000; k++) begin
      wa  = 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31));
      drv($urandom_range(0, 3) != 0, wa, $urandom, ra0, ra1, ra2, $urandom_range(0, 99) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
